sock_operand_fifo: RTL and testbench

- Upstream operand stage between the socket server wrapper's receive side and the adder DUT.
- Accepts DWIDTH_IN-bit words from the socket, buffers them in a DEPTH-entry first-word-fall-through FIFO, and splits each word into two equal operands, din0 (low half) and din1 (high half), with a valid/ready handshake.
- The socket receive side has no backpressure, so overflow drops words and flags them.

---
 rtl/sock_operand_fifo.sv | 85 ++++++++
 tb/tb_sock_operand_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sock_operand_fifo.sv
// sock_operand_fifo: FWFT operand FIFO splitting socket words into din0 (low half) / din1 (high half).
//   clk        system clock
//   rst        synchronous active-low reset
//   sock_data  socket word; sock_valid qualifies it (no backpressure, overflow drops)
//   sock_ready advisory not-full
//   din0/din1  head operands; din_valid/din_ready handshake
//   level      stored entry count; overflow sticky drop flag
//   Optional SOCK_OPERAND_FIFO_STATS_EN adds drop_cnt (saturating) and pop_cnt (wrapping).
module sock_operand_fifo #(
  parameter int DWIDTH_IN = 64,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH_IN-1:0]       sock_data,
  input  logic                       sock_valid,
  output logic                       sock_ready,
  output logic [DWIDTH_IN/2-1:0]     din0,
  output logic [DWIDTH_IN/2-1:0]     din1,
  output logic                       din_valid,
  input  logic                       din_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
`ifdef SOCK_OPERAND_FIFO_STATS_EN
  ,
  output logic [31:0]                drop_cnt,
  output logic [31:0]                pop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = DWIDTH_IN / 2;
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);
  logic [DWIDTH_IN-1:0] r_mem [DEPTH];
  logic [DWIDTH_IN-1:0] r_head;
  logic [AW-1:0]        r_wr, r_rd, w_rd_nxt;
  logic [LW-1:0]        r_level, w_lvl_nxt;
  logic                 r_overflow, w_pop, w_push, w_drop, w_last;
`ifdef SOCK_OPERAND_FIFO_STATS_EN
  logic [31:0]          r_drop_cnt, r_pop_cnt;
  assign drop_cnt = r_drop_cnt;
  assign pop_cnt  = r_pop_cnt;
`endif
  always_comb begin
    w_pop     = (r_level != '0) & din_ready;
    w_push    = sock_valid & ((r_level != L_FULL) | w_pop);
    w_drop    = sock_valid & ~w_push;
    w_rd_nxt  = r_rd + AW'(w_pop);
    // nothing stored remains after this cycle's pop, so a new head can only come from sock_data
    w_last    = r_level == LW'(w_pop);
    w_lvl_nxt = r_level + LW'(w_push) - LW'(w_pop);
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= sock_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_head     <= '0;
`ifdef SOCK_OPERAND_FIFO_STATS_EN
      r_drop_cnt <= '0;
      r_pop_cnt  <= '0;
`endif
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1'b1);
      r_rd    <= w_rd_nxt;
      r_level <= w_lvl_nxt;
      if (w_drop) r_overflow <= 1'b1;
      // registered head: holds its last value once the FIFO runs empty
      if (w_lvl_nxt != '0) r_head <= w_last ? sock_data : r_mem[w_rd_nxt];
`ifdef SOCK_OPERAND_FIFO_STATS_EN
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_pop) r_pop_cnt <= r_pop_cnt + 32'd1;
`endif
    end
  end
  assign sock_ready = r_level != L_FULL;
  assign din_valid  = r_level != '0;
  assign din0       = r_head[HW-1:0];
  assign din1       = r_head[DWIDTH_IN-1:HW];
  assign level      = r_level;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_sock_operand_fifo.sv
// tb_sock_operand_fifo: scoreboard bench for sock_operand_fifo.
module tb_sock_operand_fifo;
  logic        clk = 1'b0, rst = 1'b0;
  logic [63:0] sock_data = '0;
  logic        sock_valid = 1'b0, din_ready = 1'b0;
  logic        sock_ready, din_valid, overflow;
  logic [31:0] din0, din1;
  logic [3:0]  level;
`ifdef SOCK_OPERAND_FIFO_STATS_EN
  logic [31:0] drop_cnt, pop_cnt;
`endif
  int          checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [63:0] m_last = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_drop = '0, m_popc = '0;
  sock_operand_fifo #(.DWIDTH_IN(64), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .sock_data(sock_data), .sock_valid(sock_valid),
    .sock_ready(sock_ready), .din0(din0), .din1(din1), .din_valid(din_valid),
    .din_ready(din_ready), .level(level), .overflow(overflow)
`ifdef SOCK_OPERAND_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .pop_cnt(pop_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [63:0] hd;
    hd = (q.size() != 0) ? q[0] : m_last;
    chk("din_valid", din_valid, q.size() != 0);
    chk("din0", din0, hd[31:0]);
    chk("din1", din1, hd[63:32]);
    chk("level", level, q.size());
    chk("sock_ready", sock_ready, q.size() != 8);
    chk("overflow", overflow, m_ovf);
`ifdef SOCK_OPERAND_FIFO_STATS_EN
    chk("drop_cnt", drop_cnt, m_drop);
    chk("pop_cnt", pop_cnt, m_popc);
`endif
  endtask
  // called at a negedge: check, drive, advance model, return at the next negedge
  task automatic step(input logic sv, input logic [63:0] sd, input logic dr);
    logic pop, push;
    check_all();
    sock_valid = sv;
    sock_data  = sd;
    din_ready  = dr;
    pop  = (q.size() != 0) && dr;
    push = sv && ((q.size() < 8) || pop);
    if (pop) begin
      m_last = q.pop_front();
      m_popc++;
    end
    if (push) q.push_back(sd);
    else if (sv) begin
      m_ovf = 1'b1;
      if (m_drop != '1) m_drop++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    sock_valid = 1'b0;
    din_ready = 1'b0;
    repeat (n) @(posedge clk);
    q.delete();
    m_last = '0;
    m_ovf = 1'b0;
    m_drop = '0;
    m_popc = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    do_reset(4);
    // single word
    step(1'b1, 64'h0000_0005_0000_0003, 1'b1);
    chk("single_valid", din_valid, 1);
    chk("single_din0", din0, 32'h3);
    chk("single_din1", din1, 32'h5);
    step(1'b0, 64'h0, 1'b1);
    chk("single_level", level, 0);
    chk("single_empty", din_valid, 0);
    // fill with backpressure, then overflow
    for (int i = 0; i < 8; i++) step(1'b1, {32'(i + 1), 32'(i)}, 1'b0);
    chk("fill_level", level, 8);
    chk("fill_ready", sock_ready, 0);
    chk("fill_ovf", overflow, 0);
    step(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 8);
    chk("ovf_head", din0, 32'h0);
`ifdef SOCK_OPERAND_FIFO_STATS_EN
    chk("ovf_drop_cnt", drop_cnt, 1);
`endif
    // drain with stalls between pops
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 64'h0, 1'b0);
      chk("drain_din0", din0, 32'(i));
      step(1'b0, 64'h0, 1'b1);
    end
    chk("drain_empty", din_valid, 0);
    chk("drain_hold", din0, 32'h7);
    // full with simultaneous push/pop
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, {32'(i), 32'(100 + i)}, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, {32'(i), 32'(200 + i)}, 1'b1);
      chk("fullpp_level", level, 8);
    end
    chk("fullpp_ovf", overflow, 0);
    repeat (9) step(1'b0, 64'h0, 1'b1);
    // reset mid-stream with overflow set
    for (int i = 0; i < 9; i++) step(1'b1, {32'(i), 32'(50 + i)}, 1'b0);
    repeat (3) step(1'b0, 64'h0, 1'b1);
    chk("mid_level", level, 5);
    chk("mid_ovf", overflow, 1);
    do_reset(1);
    chk("rst_level", level, 0);
    chk("rst_valid", din_valid, 0);
    chk("rst_ovf", overflow, 0);
    step(1'b1, 64'h0000_0002_0000_0001, 1'b0);
    chk("rst_push_din0", din0, 32'h1);
    chk("rst_push_din1", din1, 32'h2);
    step(1'b0, 64'h0, 1'b1);
    // random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    repeat (10) step(1'b0, 64'h0, 1'b1);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
